// File: rtl/lbd_arbiter.sv
// lbd_arbiter
//   Shares one leading-one detector between NUM_REQ posit FPU requesters.
//   A round-robin arbiter picks one valid request whenever the output
//   register is free. The selected operand is converted to its absolute
//   value, and the detector finds the index of its leading one. The tagged
//   result is registered and presented on the response port one cycle after
//   the grant.
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   flush_i       synchronous flush: drops the held result, pointer back to 0
//   req_valid_i   per-requester request valid            [NUM_REQ]
//   req_ready_o   per-requester grant, one-hot or zero    [NUM_REQ]
//   req_data_i    operands, requester k at [k*DATA_W +: DATA_W]
//   req_signed_i  per-requester two's-complement flag     [NUM_REQ]
//   rsp_valid_o   result valid
//   rsp_ready_i   consumer accepts the result
//   rsp_id_o      requester that owns the result          [ID_W]
//   rsp_pos_o     leading-one index of |operand|, DATA_W when zero [POS_W]
//   rsp_zero_o    operand was zero
//   rsp_sign_o    operand was negative
//   rsp_abs_o     absolute value of the operand           [DATA_W]
module lbd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int POS_W   = $clog2(DATA_W) + 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_signed_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [ID_W-1:0]             rsp_id_o,
  output logic [POS_W-1:0]            rsp_pos_o,
  output logic                        rsp_zero_o,
  output logic                        rsp_sign_o,
  output logic [DATA_W-1:0]           rsp_abs_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]          ptr_q;
  logic [ID_W-1:0]          ptr_nxt;
  logic                     out_free;
  logic                     arb_en;
  logic [ID_W:0]            scan_sum;
  logic [ID_W-1:0]          scan_idx;

  logic                     gnt_vld_p0;
  logic [ID_W-1:0]          gnt_idx_p0;
  logic [NUM_REQ-1:0]       gnt_p0;
  logic signed [DATA_W-1:0] opnd_p0;
  logic                     opnd_signed_p0;
  logic                     sign_p0;
  logic [DATA_W-1:0]        abs_p0;
  logic [POS_W-1:0]         pos_p0;
  logic                     zero_p0;

  logic [ID_W-1:0]          id_p1;
  logic [POS_W-1:0]         pos_p1;
  logic                     zero_p1;
  logic                     sign_p1;
  logic [DATA_W-1:0]        abs_p1;

  // Two's-complement magnitude; the most-negative value wraps onto itself,
  // which read as unsigned is exactly its magnitude.
  function automatic logic [DATA_W-1:0] abs_fn(input logic signed [DATA_W-1:0] x,
                                               input logic                     neg);
    logic signed [DATA_W-1:0] nx;
    nx = -x;
    return neg ? $unsigned(nx) : $unsigned(x);
  endfunction

  // Highest set bit index; DATA_W when no bit is set.
  function automatic logic [POS_W-1:0] lod_fn(input logic [DATA_W-1:0] a);
    logic [POS_W-1:0] p;
    p = POS_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (a[i]) p = POS_W'(i);
    end
    return p;
  endfunction

  // ---- FSM: state register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (gnt_vld_p0) state_d = FULL;
        FULL:    if (rsp_ready_i && !gnt_vld_p0) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- FSM: outputs ----
  // The register may refill in the same cycle it drains. Holding req_ready_o
  // low while in reset keeps a grant from being issued before release.
  always_comb begin
    rsp_valid_o = (state_q == FULL);
    out_free    = (state_q == EMPTY) || rsp_ready_i;
    arb_en      = out_free && !flush_i && rst_ni;
  end

  // ---- stage p0: round-robin arbitration and operand select ----
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    if (arb_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        scan_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
        if (scan_sum >= (ID_W+1)'(NUM_REQ)) scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
        scan_idx = scan_sum[ID_W-1:0];
        if (!gnt_vld_p0 && req_valid_i[scan_idx]) begin
          gnt_vld_p0 = 1'b1;
          gnt_idx_p0 = scan_idx;
        end
      end
    end
  end

  always_comb begin
    gnt_p0 = '0;
    if (gnt_vld_p0) gnt_p0[gnt_idx_p0] = 1'b1;
  end

  assign req_ready_o = gnt_p0;
  assign ptr_nxt     = (gnt_idx_p0 == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_p0 + 1'b1;

  always_comb begin
    opnd_p0        = '0;
    opnd_signed_p0 = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx_p0 == ID_W'(k)) begin
        opnd_p0        = $signed(req_data_i[k*DATA_W +: DATA_W]);
        opnd_signed_p0 = req_signed_i[k];
      end
    end
  end

  assign sign_p0 = opnd_signed_p0 && opnd_p0[DATA_W-1];
  assign abs_p0  = abs_fn(opnd_p0, sign_p0);
  assign pos_p0  = lod_fn(abs_p0);
  assign zero_p0 = (abs_p0 == '0);

  // ---- stage p1: output register and priority pointer ----
  // Result fields only load on a grant, so they stay stable under back-pressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      id_p1   <= '0;
      pos_p1  <= '0;
      zero_p1 <= 1'b0;
      sign_p1 <= 1'b0;
      abs_p1  <= '0;
    end else if (flush_i) begin
      ptr_q   <= '0;
    end else if (gnt_vld_p0) begin
      ptr_q   <= ptr_nxt;
      id_p1   <= gnt_idx_p0;
      pos_p1  <= pos_p0;
      zero_p1 <= zero_p0;
      sign_p1 <= sign_p0;
      abs_p1  <= abs_p0;
    end
  end

  assign rsp_id_o   = id_p1;
  assign rsp_pos_o  = pos_p1;
  assign rsp_zero_o = zero_p1;
  assign rsp_sign_o = sign_p1;
  assign rsp_abs_o  = abs_p1;

endmodule

// File: tb/tb_lbd_arbiter.sv
// Testbench for lbd_arbiter: directed stimulus in one initial block, with a
// negedge monitor that predicts grants and keeps a scoreboard of expected
// responses (pushed on grant, popped when the consumer takes the result).
module tb_lbd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int POS_W   = 6;
  localparam int ID_W    = 2;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      flush_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_signed_i;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [ID_W-1:0]           rsp_id_o;
  logic [POS_W-1:0]          rsp_pos_o;
  logic                      rsp_zero_o;
  logic                      rsp_sign_o;
  logic [DATA_W-1:0]         rsp_abs_o;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [POS_W-1:0]  pos;
    logic              zero;
    logic              sign;
    logic [DATA_W-1:0] abs;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0;

  lbd_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .req_signed_i(req_signed_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_pos_o   (rsp_pos_o),
    .rsp_zero_o  (rsp_zero_o),
    .rsp_sign_o  (rsp_sign_o),
    .rsp_abs_o   (rsp_abs_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int k, input logic [DATA_W-1:0] x, input logic s);
    exp_t e;
    bit   found;
    e.id   = ID_W'(k);
    e.sign = s & x[DATA_W-1];
    e.abs  = e.sign ? (32'd0 - x) : x;
    e.zero = (e.abs == 32'd0);
    e.pos  = 6'd32;
    found  = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found && e.abs[i]) begin
        found = 1'b1;
        e.pos = 6'(i);
      end
    end
    return e;
  endfunction

  // Reference model of arbitration plus response scoreboard.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (!rst_ni) begin
        q.delete();
        m_ptr = 0;
        chk("mon_rst_valid", rsp_valid_o, 1'b0);
        chk("mon_rst_ready", req_ready_o, 4'b0000);
      end else begin
        logic [NUM_REQ-1:0] eg;
        int g;
        bit found;
        eg = '0;
        g = 0;
        found = 1'b0;
        chk("mon_valid", rsp_valid_o, (q.size() != 0));
        if (q.size() != 0) begin
          chk("mon_id",   rsp_id_o,   q[0].id);
          chk("mon_pos",  rsp_pos_o,  q[0].pos);
          chk("mon_zero", rsp_zero_o, q[0].zero);
          chk("mon_sign", rsp_sign_o, q[0].sign);
          chk("mon_abs",  rsp_abs_o,  q[0].abs);
        end
        if ((q.size() == 0 || rsp_ready_i) && !flush_i) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = (m_ptr + i) % NUM_REQ;
            if (!found && req_valid_i[j]) begin
              found = 1'b1;
              g = j;
            end
          end
        end
        if (found) eg[g] = 1'b1;
        chk("mon_grant", req_ready_o, eg);
        if (flush_i) begin
          q.delete();
          m_ptr = 0;
        end else begin
          if (q.size() != 0 && rsp_ready_i) void'(q.pop_front());
          if (found) begin
            q.push_back(model(g, req_data_i[g*DATA_W +: DATA_W], req_signed_i[g]));
            m_ptr = (g + 1) % NUM_REQ;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic one_req(input int k, input logic [DATA_W-1:0] x, input logic s,
                         input int ep, input logic ez, input logic es,
                         input logic [DATA_W-1:0] ea);
    req_valid_i  = 4'b0001 << k;
    req_data_i   = '0;
    req_data_i[k*DATA_W +: DATA_W] = x;
    req_signed_i = 4'(s) << k;
    rsp_ready_i  = 1'b1;
    step();
    req_valid_i  = '0;
    chk("one_valid", rsp_valid_o, 1'b1);
    chk("one_id",    rsp_id_o,    k);
    chk("one_pos",   rsp_pos_o,   ep);
    chk("one_zero",  rsp_zero_o,  ez);
    chk("one_sign",  rsp_sign_o,  es);
    chk("one_abs",   rsp_abs_o,   ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    req_valid_i  = '0;
    req_data_i   = '0;
    req_signed_i = '0;
    rsp_ready_i  = 1'b0;
    mon_en       = 1'b1;
    #1;
    chk("rst_valid", rsp_valid_o, 1'b0);
    chk("rst_id",    rsp_id_o,    2'd0);
    chk("rst_pos",   rsp_pos_o,   6'd0);
    chk("rst_zero",  rsp_zero_o,  1'b0);
    chk("rst_sign",  rsp_sign_o,  1'b0);
    chk("rst_abs",   rsp_abs_o,   32'd0);
    req_valid_i = 4'b1111;
    #1;
    chk("rst_ready", req_ready_o, 4'b0000);
    req_valid_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single request and signed edge values
    one_req(2, 32'h0000_0100, 1'b0, 8,  1'b0, 1'b0, 32'h0000_0100);
    one_req(0, 32'hFFFF_FFFF, 1'b1, 0,  1'b0, 1'b1, 32'h0000_0001);
    one_req(1, 32'h8000_0000, 1'b1, 31, 1'b0, 1'b1, 32'h8000_0000);
    one_req(2, 32'h8000_0000, 1'b0, 31, 1'b0, 1'b0, 32'h8000_0000);
    one_req(3, 32'h0000_0000, 1'b1, 32, 1'b1, 1'b0, 32'h0000_0000);

    // Round robin, all requesters continuously valid
    req_signed_i = '0;
    for (int k = 0; k < NUM_REQ; k++) req_data_i[k*DATA_W +: DATA_W] = 32'd1 << (k*5 + 3);
    req_valid_i = 4'b1111;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", rsp_valid_o, 1'b1);
      chk("rr_id",    rsp_id_o,    i % 4);
      chk("rr_pos",   rsp_pos_o,   (i % 4) * 5 + 3);
    end

    // Back-pressure with requester 3's result held
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", rsp_valid_o, 1'b1);
      chk("bp_id",    rsp_id_o,    2'd3);
      chk("bp_abs",   rsp_abs_o,   32'h0004_0000);
      chk("bp_ready", req_ready_o, 4'b0000);
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_release_grant", req_ready_o, 4'b0001);
    step();
    chk("bp_refill_valid", rsp_valid_o, 1'b1);
    chk("bp_refill_id",    rsp_id_o,    2'd0);

    // Flush with a held result and pending requests
    rsp_ready_i = 1'b0;
    flush_i     = 1'b1;
    #1;
    chk("flush_no_grant", req_ready_o, 4'b0000);
    step();
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    #1;
    chk("flush_valid", rsp_valid_o, 1'b0);
    chk("flush_grant", req_ready_o, 4'b0001);
    step();
    chk("flush_next_valid", rsp_valid_o, 1'b1);
    chk("flush_next_id",    rsp_id_o,    2'd0);

    // Asynchronous reset between clock edges
    step();
    chk("pre_rst_id", rsp_id_o, 2'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", rsp_valid_o, 1'b0);
    chk("arst_ready", req_ready_o, 4'b0000);
    chk("arst_abs",   rsp_abs_o,   32'd0);
    step();
    rst_ni = 1'b1;
    #1;
    chk("arst_first_grant", req_ready_o, 4'b0001);
    step();
    chk("arst_first_valid", rsp_valid_o, 1'b1);
    chk("arst_first_id",    rsp_id_o,    2'd0);

    // Drain
    req_valid_i = '0;
    repeat (3) step();
    chk("drain_valid", rsp_valid_o, 1'b0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
